// File: rtl/nor_pkg.sv
// Shared definitions for the NOR datapath block: default width and
// width-generic helpers for the set-bit counter.
package nor_pkg;

    localparam int NOR_DEFAULT_WIDTH = 4;

    // Counter width able to hold 0..width inclusive.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

    // Operands narrower than 64 bits are zero-extended by the caller.
    function automatic int popcount(input logic [63:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/nor_cell.sv
// Single-bit NOR, the leaf cell replicated across the datapath width.
module nor_cell (
    input  logic a,
    input  logic b,
    output logic y
);

    assign y = ~(a | b);

endmodule

// File: rtl/nor_gate_unit.sv
// Bitwise NOR with a combinational result plus a registered copy carrying
// a valid bit, all-ones/all-zero flags and a set-bit count.
module nor_gate_unit
    import nor_pkg::*;
#(
    parameter int WIDTH = NOR_DEFAULT_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    input  logic                       in_valid,
    output logic [WIDTH-1:0]           y,
    output logic [WIDTH-1:0]           y_q,
    output logic                       out_valid,
    output logic                       all_ones,
    output logic                       all_zero,
    output logic [cnt_w(WIDTH)-1:0]    ones_cnt
);

    localparam int CNT_W = cnt_w(WIDTH);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        nor_cell u_cell (
            .a (a[gi]),
            .b (b[gi]),
            .y (y[gi])
        );
    end

    logic [WIDTH-1:0] or_ab;
    logic [63:0]      y_ext;
    logic [CNT_W-1:0] ones_cnt_next;
    logic             all_ones_next;
    logic             all_zero_next;

    assign or_ab = a | b;

    always_comb begin
        y_ext                = '0;
        y_ext[WIDTH-1:0]     = y;
        ones_cnt_next        = CNT_W'(popcount(y_ext));
        all_ones_next        = (or_ab == '0);
        all_zero_next        = &or_ab;
    end

    logic [WIDTH-1:0] y_q_reg;
    logic             out_valid_reg;
    logic             all_ones_reg;
    logic             all_zero_reg;
    logic [CNT_W-1:0] ones_cnt_reg;

    // Reset state describes an all-zero result, so all_zero starts high.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q_reg       <= '0;
            out_valid_reg <= 1'b0;
            all_ones_reg  <= 1'b0;
            all_zero_reg  <= 1'b1;
            ones_cnt_reg  <= '0;
        end else if (in_valid) begin
            y_q_reg       <= y;
            out_valid_reg <= 1'b1;
            all_ones_reg  <= all_ones_next;
            all_zero_reg  <= all_zero_next;
            ones_cnt_reg  <= ones_cnt_next;
        end else begin
            out_valid_reg <= 1'b0;
        end
    end

    assign y_q       = y_q_reg;
    assign out_valid = out_valid_reg;
    assign all_ones  = all_ones_reg;
    assign all_zero  = all_zero_reg;
    assign ones_cnt  = ones_cnt_reg;

endmodule

// File: tb/tb_nor_gate_unit.sv
// Directed bench for nor_gate_unit at WIDTH 4, 1 and 8.
module tb_nor_gate_unit;

    logic clk;
    logic rst;

    logic [3:0] a4, b4, y4, y_q4;
    logic       iv4, ov4, ao4, az4;
    logic [2:0] cnt4;

    logic [0:0] a1, b1, y1, y_q1;
    logic       iv1, ov1, ao1, az1;
    logic [0:0] cnt1;

    logic [7:0] a8, b8, y8, y_q8;
    logic       iv8, ov8, ao8, az8;
    logic [3:0] cnt8;

    int checks;
    int errors;

    nor_gate_unit #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .a(a4), .b(b4), .in_valid(iv4),
        .y(y4), .y_q(y_q4), .out_valid(ov4), .all_ones(ao4),
        .all_zero(az4), .ones_cnt(cnt4)
    );

    nor_gate_unit #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .in_valid(iv1),
        .y(y1), .y_q(y_q1), .out_valid(ov1), .all_ones(ao1),
        .all_zero(az1), .ones_cnt(cnt1)
    );

    nor_gate_unit #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .in_valid(iv8),
        .y(y8), .y_q(y_q8), .out_valid(ov8), .all_ones(ao8),
        .all_zero(az8), .ones_cnt(cnt8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Directed vectors: a, b, hand-computed ~(a|b)
    logic [3:0] vec_a [10] = '{4'b0000, 4'b1010, 4'b1100, 4'b1011, 4'b1001,
                               4'b0010, 4'b1101, 4'b0000, 4'b1111, 4'b0111};
    logic [3:0] vec_b [10] = '{4'b0000, 4'b0101, 4'b1100, 4'b0000, 4'b1000,
                               4'b0111, 4'b0101, 4'b1101, 4'b1111, 4'b0100};
    logic [3:0] vec_y [10] = '{4'b1111, 4'b0000, 4'b0011, 4'b0100, 4'b0110,
                               4'b1000, 4'b0010, 4'b0010, 4'b0000, 4'b1000};
    // Hand-computed set-bit counts of vec_y
    int         vec_c [10] = '{4, 0, 2, 1, 2, 1, 1, 1, 0, 1};

    task automatic check4_reg(input string tag, input logic [3:0] ey, input logic eov,
                              input logic eao, input logic eaz, input logic [2:0] ec);
        checks++;
        if (y_q4 !== ey || ov4 !== eov || ao4 !== eao || az4 !== eaz || cnt4 !== ec) begin
            errors++;
            $display("FAIL %s: y_q=%b ov=%b ao=%b az=%b cnt=%0d, expected y_q=%b ov=%b ao=%b az=%b cnt=%0d",
                     tag, y_q4, ov4, ao4, az4, cnt4, ey, eov, eao, eaz, ec);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check4_reg("reset_w4", 4'b0000, 1'b0, 1'b0, 1'b1, 3'd0);
        checks++;
        if (y_q1 !== 1'b0 || ov1 !== 1'b0 || ao1 !== 1'b0 || az1 !== 1'b1 || cnt1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_w1: y_q=%b ov=%b ao=%b az=%b cnt=%0d, expected 0 0 0 1 0",
                     y_q1, ov1, ao1, az1, cnt1);
        end
        checks++;
        if (y_q8 !== 8'h00 || ov8 !== 1'b0 || ao8 !== 1'b0 || az8 !== 1'b1 || cnt8 !== 4'd0) begin
            errors++;
            $display("FAIL reset_w8: y_q=%h ov=%b ao=%b az=%b cnt=%0d, expected 00 0 0 1 0",
                     y_q8, ov8, ao8, az8, cnt8);
        end
        $display("reset: outputs cleared");
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_comb();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            a4 = vec_a[i]; b4 = vec_b[i]; iv4 = 1'b0;
            #1;
            checks++;
            if (y4 !== vec_y[i]) begin
                errors++;
                $display("FAIL comb[%0d]: y=%b, expected %b", i, y4, vec_y[i]);
            end
            $display("comb: a=%b b=%b y=%b", a4, b4, y4);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            a4 = vec_a[i]; b4 = vec_b[i]; iv4 = 1'b1;
            @(posedge clk);
            #1;
            check4_reg($sformatf("reg[%0d]", i), vec_y[i], 1'b1,
                       vec_c[i] == 4, vec_c[i] == 0, 3'(vec_c[i]));
            $display("reg: a=%b b=%b y_q=%b cnt=%0d", vec_a[i], vec_b[i], y_q4, cnt4);
        end
    endtask

    task automatic test_hold();
        logic [3:0] ra, rb;
        @(negedge clk);
        a4 = 4'b1001; b4 = 4'b1000; iv4 = 1'b1;
        @(posedge clk);
        #1;
        check4_reg("hold_load", 4'b0110, 1'b1, 1'b0, 1'b0, 3'd2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ra = 4'($urandom); rb = 4'($urandom);
            a4 = ra; b4 = rb; iv4 = 1'b0;
            #1;
            checks++;
            if (y4 !== ~(ra | rb)) begin
                errors++;
                $display("FAIL hold_comb[%0d]: y=%b, expected %b", i, y4, ~(ra | rb));
            end
            @(posedge clk);
            #1;
            check4_reg($sformatf("hold[%0d]", i), 4'b0110, 1'b0, 1'b0, 1'b0, 3'd2);
            $display("hold: a=%b b=%b y=%b y_q=%b ov=%b", ra, rb, y4, y_q4, ov4);
        end
    endtask

    task automatic test_reset_priority();
        @(negedge clk);
        rst = 1'b1; a4 = 4'b0000; b4 = 4'b0000; iv4 = 1'b1;
        @(posedge clk);
        #1;
        check4_reg("rst_prio", 4'b0000, 1'b0, 1'b0, 1'b1, 3'd0);
        checks++;
        if (y4 !== 4'b1111) begin
            errors++;
            $display("FAIL rst_comb: y=%b, expected 1111", y4);
        end
        $display("rst_prio: y_q=%b az=%b ov=%b", y_q4, az4, ov4);
        @(negedge clk);
        rst = 1'b0; a4 = 4'b0111; b4 = 4'b0100; iv4 = 1'b1;
        @(posedge clk);
        #1;
        check4_reg("after_rst", 4'b1000, 1'b1, 1'b0, 1'b0, 3'd1);
        $display("after_rst: y_q=%b", y_q4);
        @(negedge clk);
        iv4 = 1'b0;
    endtask

    task automatic test_width1();
        // Hand table: only 0/0 produces a 1
        logic [1:0] pat;
        logic       ey;
        for (int i = 0; i < 4; i++) begin
            pat = 2'(i);
            ey  = (i == 0);
            @(negedge clk);
            a1 = pat[1]; b1 = pat[0]; iv1 = 1'b1;
            #1;
            checks++;
            if (y1 !== ey) begin
                errors++;
                $display("FAIL w1_comb[%0d]: y=%b, expected %b", i, y1, ey);
            end
            @(posedge clk);
            #1;
            checks++;
            if (y_q1 !== ey || ov1 !== 1'b1 || ao1 !== ey || az1 !== ~ey || cnt1 !== ey
                || (ao1 && az1)) begin
                errors++;
                $display("FAIL w1_reg[%0d]: y_q=%b ov=%b ao=%b az=%b cnt=%0d, expected %b 1 %b %b %0d",
                         i, y_q1, ov1, ao1, az1, cnt1, ey, ey, ~ey, ey);
            end
            $display("w1: a=%b b=%b y_q=%b", a1, b1, y_q1);
        end
        @(negedge clk);
        iv1 = 1'b0;
    endtask

    task automatic test_width8();
        logic [7:0] ra, rb, ey;
        int         ec;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            ra = 8'($urandom); rb = 8'($urandom);
            // Bias some cycles towards the all-ones / all-zero corners
            if (i % 50 == 0) begin ra = 8'h00; rb = 8'h00; end
            if (i % 50 == 25) rb = ~ra;
            ey = ~(ra | rb);
            ec = $countones(ey);
            a8 = ra; b8 = rb; iv8 = 1'b1;
            #1;
            checks++;
            if (y8 !== ey) begin
                errors++;
                $display("FAIL w8_comb[%0d]: y=%h, expected %h", i, y8, ey);
            end
            @(posedge clk);
            #1;
            checks++;
            if (y_q8 !== ey || ov8 !== 1'b1 || cnt8 !== 4'(ec)
                || ao8 !== (ey == 8'hff) || az8 !== (ey == 8'h00)) begin
                errors++;
                $display("FAIL w8_reg[%0d]: y_q=%h ov=%b ao=%b az=%b cnt=%0d, expected y_q=%h cnt=%0d",
                         i, y_q8, ov8, ao8, az8, cnt8, ey, ec);
            end
            checks++;
            if ((ao8 && az8) || cnt8 > 4'd8 || ((cnt8 == 4'd8) !== ao8) || ((cnt8 == 4'd0) !== az8)) begin
                errors++;
                $display("FAIL w8_inv[%0d]: ao=%b az=%b cnt=%0d, required consistent flags",
                         i, ao8, az8, cnt8);
            end
            $display("w8: a=%h b=%h y_q=%h cnt=%0d", ra, rb, y_q8, cnt8);
        end
        @(negedge clk);
        iv8 = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        a4 = '0; b4 = '0; iv4 = 1'b0;
        a1 = '0; b1 = '0; iv1 = 1'b0;
        a8 = '0; b8 = '0; iv8 = 1'b0;
        test_reset();
        test_comb();
        test_back_to_back();
        test_hold();
        test_reset_priority();
        test_width1();
        test_width8();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
